// File: rtl/matrix_alu_sequencer.sv
// matrix_alu_sequencer: runs one 4x4 x 16-bit matrix operation end to end on the matrix ALU.
// It fetches operands from matrix memory, loads them into the ALU, issues the execute
// opcode, waits for the ALU status and writes the result back to memory.
// Optional build macro SEQ_TIMEOUT_EN bounds the READ wait to TIMEOUT cycles and retires the
// command with err=1 when the bound expires.
// mem_rdata_i is sampled at the clock edge that closes the read strobe cycle, so the operand
// is on alu_o during the following LOAD cycle.
module matrix_alu_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [7:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_src_a_i,
    input  logic [ADDR_W-1:0] cmd_src_b_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [15:0]       cmd_scalar_i,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              alu_enable_o,
    output logic              alu_readwrite_o,
    output logic [7:0]        alu_opcode_o,
    output logic [DATA_W-1:0] alu_in_o,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic              alu_status_i
);

    localparam logic [7:0] OpAdd   = 8'h81;
    localparam logic [7:0] OpSub   = 8'h82;
    localparam logic [7:0] OpMult  = 8'h83;
    localparam logic [7:0] OpTrans = 8'h85;
    localparam logic [7:0] OpScale = 8'hBC;
    localparam logic [7:0] OpLoad  = 8'h01;

    typedef enum logic [3:0] {
        StIdle,
        StFetchA,
        StLoadA,
        StFetchB,
        StLoadB,
        StExec,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [15:0]       scalar_q, scalar_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              alu_enable_q, alu_enable_d;
    logic              alu_readwrite_q, alu_readwrite_d;
    logic [7:0]        alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_in_q, alu_in_d;

    logic accept;
    logic op_legal;

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

    assign cmd_ready_o = (state_q == StIdle) && rst_ni;
    assign busy_o      = (state_q != StIdle);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign op_legal    = cmd_op_i inside {OpAdd, OpSub, OpMult, OpTrans, OpScale};

    // Next state, command latch, result capture and registered-output next values.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        scalar_d = scalar_q;
        result_d = result_q;
        err_d    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = cmd_op_i;
                    src_a_d  = cmd_src_a_i;
                    src_b_d  = cmd_src_b_i;
                    dst_d    = cmd_dst_i;
                    scalar_d = cmd_scalar_i;
                    if (op_legal) begin
                        state_d = StFetchA;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StFetchA: state_d = StLoadA;
            StLoadA: begin
                if (op_q == OpTrans) begin
                    state_d = StExec;
                end else if (op_q == OpScale) begin
                    state_d = StLoadB;
                end else begin
                    state_d = StFetchB;
                end
            end
            StFetchB: state_d = StLoadB;
            StLoadB:  state_d = StExec;
            StExec: begin
                state_d = StRead;
`ifdef SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StRead: begin
                // A status arriving on the final allowed cycle still completes normally.
                if (alu_status_i) begin
                    result_d = alu_out_i;
                    state_d  = StWrite;
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    if (wait_cnt_d >= TIMEOUT) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the state being entered so they line up with that state.
        done_d          = (state_d == StDone);
        mem_en_d        = state_d inside {StFetchA, StFetchB, StWrite};
        mem_rw_d        = (state_d == StWrite);
        alu_enable_d    = state_d inside {StLoadA, StLoadB, StRead};
        alu_readwrite_d = (state_d == StRead);

        alu_opcode_d = 8'h00;
        if (state_d inside {StLoadA, StLoadB, StRead}) begin
            alu_opcode_d = OpLoad;
        end else if (state_d == StExec) begin
            alu_opcode_d = op_d;
        end

        mem_addr_d = mem_addr_q;
        if (state_d == StFetchA) begin
            mem_addr_d = src_a_d;
        end else if (state_d == StFetchB) begin
            mem_addr_d = src_b_d;
        end else if (state_d == StWrite) begin
            mem_addr_d = dst_d;
        end

        alu_in_d = alu_in_q;
        if (state_d == StLoadA) begin
            alu_in_d = mem_rdata_i;
        end else if (state_d == StLoadB) begin
            alu_in_d = (op_d == OpScale) ? {{(DATA_W-16){1'b0}}, scalar_d} : mem_rdata_i;
        end

        mem_wdata_d = mem_wdata_q;
        if (state_d == StWrite) begin
            mem_wdata_d = result_d;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            op_q            <= '0;
            src_a_q         <= '0;
            src_b_q         <= '0;
            dst_q           <= '0;
            scalar_q        <= '0;
            result_q        <= '0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            mem_en_q        <= 1'b0;
            mem_rw_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            alu_enable_q    <= 1'b0;
            alu_readwrite_q <= 1'b0;
            alu_opcode_q    <= '0;
            alu_in_q        <= '0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            src_a_q         <= src_a_d;
            src_b_q         <= src_b_d;
            dst_q           <= dst_d;
            scalar_q        <= scalar_d;
            result_q        <= result_d;
            done_q          <= done_d;
            err_q           <= err_d;
            mem_en_q        <= mem_en_d;
            mem_rw_q        <= mem_rw_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            alu_enable_q    <= alu_enable_d;
            alu_readwrite_q <= alu_readwrite_d;
            alu_opcode_q    <= alu_opcode_d;
            alu_in_q        <= alu_in_d;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
`endif
        end
    end

    assign done_o          = done_q;
    assign err_o           = err_q;
    assign mem_en_o        = mem_en_q;
    assign mem_rw_o        = mem_rw_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign alu_enable_o    = alu_enable_q;
    assign alu_readwrite_o = alu_readwrite_q;
    assign alu_opcode_o    = alu_opcode_q;
    assign alu_in_o        = alu_in_q;

endmodule
